uart_tx_fifo: RTL and testbench

Byte FIFO plus transmit handshake controller that sits between the receive path and uart_tx in the loopback design. It absorbs back-to-back received bytes (one-cycle valid strobes) and feeds them to uart_tx one at a time using the req/busy handshake. This prevents byte loss while the transmitter is busy and reports overflow when the buffer is exhausted.

---
 rtl/uart_tx_fifo.sv | 126 ++++++++++++
 tb/tb_uart_tx_fifo.sv | 233 +++++++++++++++++++++++
 2 files changed

// File: rtl/uart_tx_fifo.sv
// Byte FIFO with a req/busy handshake controller that feeds uart_tx one byte at a time.
// Flags are registered from the post-edge count; a write while full is dropped and latched in overflow.
module uart_tx_fifo #(
  parameter int ADDR_W = 4
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [7:0]        byte_in,
  input  logic              valid_in,
  input  logic              tx_busy,
  output logic              tx_req,
  output logic [7:0]        byte_out,
  output logic [ADDR_W:0]   count,
  output logic              empty,
  output logic              full,
  output logic              overflow,
  input  logic              ovf_clr
);

  localparam int unsigned DEPTH = 2**ADDR_W;
  localparam logic [ADDR_W:0] FULL_CNT = {1'b1, {ADDR_W{1'b0}}};

  typedef enum logic [1:0] {
    S_IDLE,
    S_REQ,
    S_WAIT
  } state_t;

  logic [7:0]        r_mem [DEPTH];
  logic [ADDR_W-1:0] r_wr_ptr;
  logic [ADDR_W-1:0] r_rd_ptr;
  logic [ADDR_W:0]   r_count;
  logic              r_empty;
  logic              r_full;
  logic              r_overflow;
  logic              r_tx_req;
  logic [7:0]        r_byte_out;
  state_t            r_state;

  logic              w_wr;
  logic              w_drop;
  logic              w_pop;
  logic [ADDR_W:0]   w_count_nxt;

  assign w_wr   = valid_in & ~r_full;
  assign w_drop = valid_in &  r_full;
  assign w_pop  = (r_state == S_IDLE) & ~r_empty & ~tx_busy;

  always_comb begin
    w_count_nxt = r_count;
    if (w_wr && !w_pop) begin
      w_count_nxt = r_count + (ADDR_W+1)'(1);
    end else if (!w_wr && w_pop) begin
      w_count_nxt = r_count - (ADDR_W+1)'(1);
    end
  end

  // Storage is deliberately left out of reset.
  always_ff @(posedge clk) begin
    if (w_wr) begin
      r_mem[r_wr_ptr] <= byte_in;
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_wr_ptr   <= '0;
      r_rd_ptr   <= '0;
      r_count    <= '0;
      r_empty    <= 1'b1;
      r_full     <= 1'b0;
      r_overflow <= 1'b0;
      r_tx_req   <= 1'b0;
      r_byte_out <= '0;
      r_state    <= S_IDLE;
    end else begin
      if (w_wr) begin
        r_wr_ptr <= r_wr_ptr + ADDR_W'(1);
      end
      r_count <= w_count_nxt;
      r_empty <= (w_count_nxt == '0);
      r_full  <= (w_count_nxt == FULL_CNT);

      // A drop on the same edge as a clear keeps the flag set.
      if (w_drop) begin
        r_overflow <= 1'b1;
      end else if (ovf_clr) begin
        r_overflow <= 1'b0;
      end

      case (r_state)
        S_IDLE: begin
          if (w_pop) begin
            r_byte_out <= r_mem[r_rd_ptr];
            r_rd_ptr   <= r_rd_ptr + ADDR_W'(1);
            r_tx_req   <= 1'b1;
            r_state    <= S_REQ;
          end
        end
        S_REQ: begin
          if (tx_busy) begin
            r_tx_req <= 1'b0;
            r_state  <= S_WAIT;
          end
        end
        S_WAIT: begin
          if (!tx_busy) begin
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_tx_req <= 1'b0;
          r_state  <= S_IDLE;
        end
      endcase
    end
  end

  assign tx_req   = r_tx_req;
  assign byte_out = r_byte_out;
  assign count    = r_count;
  assign empty    = r_empty;
  assign full     = r_full;
  assign overflow = r_overflow;

endmodule

// File: tb/tb_uart_tx_fifo.sv
// Bench for uart_tx_fifo: queue-based reference model, a behavioural uart_tx stand-in, directed tests.
module tb_uart_tx_fifo;

  localparam int AW    = 4;
  localparam int DEPTH = 16;

  logic          clk = 1'b0;
  logic          rst_n = 1'b1;
  logic [7:0]    byte_in = '0;
  logic          valid_in = 1'b0;
  logic          tx_busy;
  logic          ovf_clr = 1'b0;
  logic          tx_req;
  logic [7:0]    byte_out;
  logic [AW:0]   count;
  logic          empty;
  logic          full;
  logic          overflow;

  logic          force_busy = 1'b0;
  logic          xm_busy = 1'b0;
  assign tx_busy = force_busy | xm_busy;

  uart_tx_fifo #(.ADDR_W(AW)) dut (
    .clk      (clk),
    .rst_n    (rst_n),
    .byte_in  (byte_in),
    .valid_in (valid_in),
    .tx_busy  (tx_busy),
    .tx_req   (tx_req),
    .byte_out (byte_out),
    .count    (count),
    .empty    (empty),
    .full     (full),
    .overflow (overflow),
    .ovf_clr  (ovf_clr)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic chk(input string nm, input int act, input int exp);
    checks++;
    if (act != exp) begin
      errors++;
      $display("FAIL %s actual=%0d required=%0d (t=%0t)", nm, act, exp, $time);
    end
  endtask

  // Reference model: bytes held, handshake phase, presented byte, sticky flag.
  logic [7:0] mq[$];
  bit         m_req = 0;
  logic [7:0] m_out = '0;
  int         m_phase = 0;
  bit         m_ovf = 0;
  bit         m_pop, m_wr, m_drop;

  initial forever begin
    @(posedge clk or negedge rst_n);
    if (!rst_n) begin
      mq.delete();
      m_req = 0; m_out = '0; m_phase = 0; m_ovf = 0;
    end else begin
      m_pop  = (m_phase == 0) && (mq.size() != 0) && !tx_busy;
      m_wr   = valid_in && (mq.size() < DEPTH);
      m_drop = valid_in && (mq.size() == DEPTH);
      if (m_phase == 0 && m_pop) begin
        m_out = mq.pop_front();
        m_req = 1; m_phase = 1;
      end else if (m_phase == 1 && tx_busy) begin
        m_req = 0; m_phase = 2;
      end else if (m_phase == 2 && !tx_busy) begin
        m_phase = 0;
      end
      if (m_wr) mq.push_back(byte_in);
      if (m_drop) m_ovf = 1;
      else if (ovf_clr) m_ovf = 0;
    end
  end

  int peak = 0;
  initial forever begin
    @(negedge clk);
    chk("cmp_tx_req",   tx_req,   m_req);
    chk("cmp_byte_out", byte_out, m_out);
    chk("cmp_count",    count,    mq.size());
    chk("cmp_empty",    empty,    mq.size() == 0);
    chk("cmp_full",     full,     mq.size() == DEPTH);
    chk("cmp_overflow", overflow, m_ovf);
    if (int'(count) > peak) peak = count;
  end

  // uart_tx stand-in: raises busy xm_delay cycles after seeing a request, holds it xm_hold cycles.
  int xs = 0, wcnt = 0, hcnt = 0;
  int xm_delay = 2, xm_hold = 100;
  logic [7:0] sent[$];

  initial forever begin
    @(negedge clk);
    if (!rst_n) begin
      xs = 0; xm_busy = 1'b0;
    end else begin
      case (xs)
        0: if (tx_req && !force_busy) begin wcnt = xm_delay; xs = 1; end
        1: if (wcnt == 0) begin
             xm_busy = 1'b1; sent.push_back(byte_out); hcnt = xm_hold; xs = 2;
           end else wcnt--;
        2: if (hcnt == 0) begin xm_busy = 1'b0; xs = 0; end else hcnt--;
        default: xs = 0;
      endcase
    end
  end

  task automatic write_byte(input logic [7:0] b);
    @(negedge clk);
    valid_in = 1'b1; byte_in = b;
  endtask

  task automatic wait_sent(input string nm, input int n, input int budget);
    int k = 0;
    while (sent.size() < n && k < budget) begin
      @(negedge clk);
      k++;
    end
    chk(nm, sent.size(), n);
  endtask

  task automatic chk_sent(input string nm, input int idx, input int exp);
    chk(nm, (idx < sent.size()) ? int'(sent[idx]) : -1, exp);
  endtask

  initial begin
    rst_n = 1'b0;
    repeat (3) @(negedge clk);
    rst_n = 1'b1;
    chk("rst_tx_req", tx_req, 0);
    chk("rst_byte_out", byte_out, 0);
    chk("rst_count", count, 0);
    chk("rst_empty", empty, 1);

    // Single byte latency and handshake.
    write_byte(8'hA5);
    @(negedge clk); valid_in = 1'b0;
    chk("lat_req_n", tx_req, 0);
    chk("lat_cnt_n", count, 1);
    @(negedge clk);
    chk("lat_req_n1", tx_req, 1);
    chk("lat_byte_n1", byte_out, 8'hA5);
    chk("lat_cnt_n1", count, 0);
    repeat (3) @(negedge clk);
    chk("req_held", tx_req, 1);
    @(negedge clk);
    chk("req_drop", tx_req, 0);
    repeat (105) @(negedge clk);
    chk("single_n", sent.size(), 1);
    chk_sent("single_b", 0, 8'hA5);
    chk("single_empty", empty, 1);

    // Burst ordering with a slow transmitter.
    sent.delete(); peak = 0;
    for (int i = 1; i <= 5; i++) write_byte(8'(i * 8'h11));
    @(negedge clk); valid_in = 1'b0;
    wait_sent("burst_wait", 5, 1500);
    for (int i = 0; i < 5; i++) chk_sent("burst_b", i, (i + 1) * 8'h11);
    chk("burst_peak_ok", (peak == 4 || peak == 5), 1);
    repeat (110) @(negedge clk);

    // Fill, overflow, clear priority, drain.
    sent.delete();
    @(negedge clk); force_busy = 1'b1;
    for (int i = 0; i < 16; i++) write_byte(8'(i));
    @(negedge clk);
    chk("full_16", full, 1);
    chk("full_cnt", count, 16);
    chk("full_ovf0", overflow, 0);
    byte_in = 8'h10;
    @(negedge clk); valid_in = 1'b0;
    chk("drop_ovf", overflow, 1);
    chk("drop_cnt", count, 16);
    ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    chk("clr_ovf", overflow, 0);
    valid_in = 1'b1; byte_in = 8'h11; ovf_clr = 1'b1;
    @(negedge clk); valid_in = 1'b0; ovf_clr = 1'b0;
    chk("clr_vs_drop", overflow, 1);
    ovf_clr = 1'b1;
    @(negedge clk); ovf_clr = 1'b0;
    xm_hold = 3; force_busy = 1'b0;
    wait_sent("drain_wait", 16, 800);
    for (int i = 0; i < 16; i++) chk_sent("drain_b", i, i);
    repeat (20) @(negedge clk);
    chk("drain_empty", empty, 1);

    // Streaming with random gaps, wrapping the pointers twice.
    sent.delete(); xm_delay = 0; xm_hold = 2;
    for (int i = 0; i < 40; i++) begin
      write_byte(8'(i));
      @(negedge clk); valid_in = 1'b0;
      repeat ($urandom_range(2, 10)) @(negedge clk);
    end
    wait_sent("wrap_wait", 40, 1000);
    repeat (20) @(negedge clk);
    chk("wrap_n", sent.size(), 40);
    for (int i = 0; i < 40; i++) chk_sent("wrap_b", i, i);
    chk("wrap_ovf", overflow, 0);

    // Reset while a request is pending with bytes queued.
    sent.delete(); xm_delay = 1000;
    for (int i = 0; i < 7; i++) write_byte(8'(8'hC0 + i));
    @(negedge clk); valid_in = 1'b0;
    repeat (2) @(negedge clk);
    chk("pre_rst_req", tx_req, 1);
    chk("pre_rst_cnt", count, 6);
    #2 rst_n = 1'b0;
    #1;
    chk("arst_req", tx_req, 0);
    chk("arst_cnt", count, 0);
    chk("arst_byte", byte_out, 0);
    chk("arst_ovf", overflow, 0);
    chk("arst_empty", empty, 1);
    repeat (2) @(negedge clk);
    rst_n = 1'b1; xm_delay = 2;
    repeat (100) @(negedge clk);
    chk("post_rst_sent", sent.size(), 0);
    chk("post_rst_req", tx_req, 0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
